// File: rtl/motion_bbox_tracker.sv
// Frame-difference motion detector: per-pixel luma threshold mask plus a
// per-frame motion bounding box published once after each frame ends.
module motion_bbox_tracker #(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned XW      = 10,
    parameter int unsigned YW      = 10,
    parameter int unsigned CW      = 19,
    parameter int unsigned MIN_PIX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    diff_threshold,
    input  logic [7:0]    y_cur,
    input  logic [7:0]    y_pre,
    input  logic          frame_vsync,
    input  logic          frame_href,
    input  logic          frame_clken,
    output logic          mask_clken,
    output logic          mask_bit,
    output logic          box_valid,
    output logic          box_found,
    output logic [XW-1:0] box_xmin,
    output logic [XW-1:0] box_xmax,
    output logic [YW-1:0] box_ymin,
    output logic [YW-1:0] box_ymax,
    output logic [CW-1:0] box_count,
    output logic          geom_err
);

    localparam logic [2:0] StSync    = 3'd0;
    localparam logic [2:0] StActive  = 3'd1;
    localparam logic [2:0] StDrain   = 3'd2;
    localparam logic [2:0] StPublish = 3'd3;
    localparam logic [2:0] StBlank   = 3'd4;

    localparam logic [XW-1:0] XMax = {XW{1'b1}};
    localparam logic [YW-1:0] YMax = {YW{1'b1}};
    localparam logic [CW-1:0] CMax = {CW{1'b1}};

    logic [2:0] state_q, state_d;
    logic       vsync_q, href_q;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    logic          s1_valid_q, s1_motion_q, s1_inwin_q, s1_act_q;
    logic [XW-1:0] s1_x_q;
    logic [YW-1:0] s1_y_q;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic          err_q, err_d;

    logic          box_valid_q, box_found_q, geom_err_q;
    logic [XW-1:0] box_xmin_q, box_xmax_q;
    logic [YW-1:0] box_ymin_q, box_ymax_q;
    logic [CW-1:0] box_count_q;

    logic       pix_vld, href_fall, in_win, motion, acc_hit, acc_oow, found;
    logic [7:0] pix_diff;

    assign pix_vld   = frame_href & frame_clken;
    assign href_fall = href_q & ~frame_href;
    assign pix_diff  = (y_cur >= y_pre) ? (y_cur - y_pre) : (y_pre - y_cur);
    assign motion    = pix_diff > diff_threshold;
    assign in_win    = (33'(x_q) < 33'(IMG_W)) && (33'(y_q) < 33'(IMG_H));
    assign found     = 33'(cnt_q) >= 33'(MIN_PIX);

    // Only pixels captured while ACTIVE may touch the accumulators.
    assign acc_hit = s1_valid_q & s1_act_q & s1_inwin_q & s1_motion_q;
    assign acc_oow = s1_valid_q & s1_act_q & ~s1_inwin_q;

    // SYNC waits for a blanking interval before the first ACTIVE frame, so a
    // frame interrupted by reset is never published.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSync:    if (frame_vsync) state_d = StBlank;
            StActive:  if (frame_vsync && !vsync_q) state_d = StDrain;
            StDrain:   state_d = StPublish;
            StPublish: state_d = StBlank;
            StBlank:   if (!frame_vsync) state_d = StActive;
            default:   state_d = StSync;
        endcase
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (state_q == StPublish || state_q == StBlank || state_q == StSync) begin
            x_d = '0;
            y_d = '0;
        end else begin
            if (href_fall) begin
                x_d = '0;
                if (y_q != YMax) y_d = y_q + YW'(1);
            end else if (pix_vld && x_q != XMax) begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        err_d  = err_q;
        if (state_q == StPublish || state_q == StSync) begin
            cnt_d  = '0;
            xmin_d = XMax;
            xmax_d = '0;
            ymin_d = YMax;
            ymax_d = '0;
            err_d  = 1'b0;
        end else begin
            if (acc_hit) begin
                if (cnt_q != CMax) cnt_d = cnt_q + CW'(1);
                if (s1_x_q < xmin_q) xmin_d = s1_x_q;
                if (s1_x_q > xmax_q) xmax_d = s1_x_q;
                if (s1_y_q < ymin_q) ymin_d = s1_y_q;
                if (s1_y_q > ymax_q) ymax_d = s1_y_q;
            end
            if (acc_oow) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StSync;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            vsync_q <= frame_vsync;
            href_q  <= frame_href;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_motion_q <= 1'b0;
            s1_inwin_q  <= 1'b0;
            s1_act_q    <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
        end else begin
            s1_valid_q  <= pix_vld;
            s1_motion_q <= pix_vld & motion;
            s1_inwin_q  <= in_win;
            s1_act_q    <= (state_q == StActive);
            s1_x_q      <= x_q;
            s1_y_q      <= y_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            xmin_q <= XMax;
            xmax_q <= '0;
            ymin_q <= YMax;
            ymax_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_valid_q <= 1'b0;
            box_found_q <= 1'b0;
            box_xmin_q  <= '0;
            box_xmax_q  <= '0;
            box_ymin_q  <= '0;
            box_ymax_q  <= '0;
            box_count_q <= '0;
            geom_err_q  <= 1'b0;
        end else begin
            box_valid_q <= (state_q == StPublish);
            if (state_q == StPublish) begin
                box_found_q <= found;
                box_xmin_q  <= found ? xmin_q : '0;
                box_xmax_q  <= found ? xmax_q : '0;
                box_ymin_q  <= found ? ymin_q : '0;
                box_ymax_q  <= found ? ymax_q : '0;
                box_count_q <= cnt_q;
                geom_err_q  <= err_q;
            end
        end
    end

    assign mask_clken = s1_valid_q;
    assign mask_bit   = s1_motion_q;
    assign box_valid  = box_valid_q;
    assign box_found  = box_found_q;
    assign box_xmin   = box_xmin_q;
    assign box_xmax   = box_xmax_q;
    assign box_ymin   = box_ymin_q;
    assign box_ymax   = box_ymax_q;
    assign box_count  = box_count_q;
    assign geom_err   = geom_err_q;

endmodule

// File: tb/tb_motion_bbox_tracker.sv
// Scoreboard bench for motion_bbox_tracker: a full-width instance and a CW=3
// instance share stimulus; expected masks and boxes are queued at drive time.
module tb_motion_bbox_tracker;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 6;
    localparam int unsigned MP = 2;

    typedef struct {
        logic        found;
        logic [9:0]  xmin, xmax, ymin, ymax;
        logic [31:0] count;
        logic        err;
        int          cyc;
    } box_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] thr, y_cur, y_pre;
    logic       vs, href, clken;

    logic       mclk, mbit, bval, bfound, gerr;
    logic [9:0] bxmin, bxmax, bymin, bymax;
    logic [18:0] bcount;

    logic       mclk_s, mbit_s, bval_s, bfound_s, gerr_s;
    logic [9:0] bxmin_s, bxmax_s, bymin_s, bymax_s;
    logic [2:0] bcount_s;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    logic [7:0] img_cur [0:7][0:11];
    logic [7:0] img_pre [0:7][0:11];

    box_exp_t bq[$];
    box_exp_t sq[$];
    logic     mq[$];

    motion_bbox_tracker #(
        .IMG_W(W), .IMG_H(H), .XW(10), .YW(10), .CW(19), .MIN_PIX(MP)
    ) dut (
        .clk(clk), .rst(rst), .diff_threshold(thr), .y_cur(y_cur), .y_pre(y_pre),
        .frame_vsync(vs), .frame_href(href), .frame_clken(clken),
        .mask_clken(mclk), .mask_bit(mbit), .box_valid(bval), .box_found(bfound),
        .box_xmin(bxmin), .box_xmax(bxmax), .box_ymin(bymin), .box_ymax(bymax),
        .box_count(bcount), .geom_err(gerr)
    );

    motion_bbox_tracker #(
        .IMG_W(W), .IMG_H(H), .XW(10), .YW(10), .CW(3), .MIN_PIX(MP)
    ) dut_s (
        .clk(clk), .rst(rst), .diff_threshold(thr), .y_cur(y_cur), .y_pre(y_pre),
        .frame_vsync(vs), .frame_href(href), .frame_clken(clken),
        .mask_clken(mclk_s), .mask_bit(mbit_s), .box_valid(bval_s), .box_found(bfound_s),
        .box_xmin(bxmin_s), .box_xmax(bxmax_s), .box_ymin(bymin_s), .box_ymax(bymax_s),
        .box_count(bcount_s), .geom_err(gerr_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic motion_of(input logic [7:0] c, input logic [7:0] p,
                                       input logic [7:0] t);
        int d;
        d = (int'(c) > int'(p)) ? int'(c) - int'(p) : int'(p) - int'(c);
        return d > int'(t);
    endfunction

    function automatic box_exp_t model_box(input int nl, input int np, input logic [7:0] t,
                                           input int cmax, input int at_cyc);
        box_exp_t e;
        int cnt = 0;
        int xmn = 1023, xmx = 0, ymn = 1023, ymx = 0;
        e.err = 1'b0;
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < np; p++) begin
                if (p < int'(W) && l < int'(H)) begin
                    if (motion_of(img_cur[l][p], img_pre[l][p], t)) begin
                        cnt++;
                        if (p < xmn) xmn = p;
                        if (p > xmx) xmx = p;
                        if (l < ymn) ymn = l;
                        if (l > ymx) ymx = l;
                    end
                end else begin
                    e.err = 1'b1;
                end
            end
        end
        if (cnt > cmax) cnt = cmax;
        e.count = 32'(cnt);
        e.found = (cnt >= int'(MP));
        e.xmin  = e.found ? 10'(xmn) : 10'd0;
        e.xmax  = e.found ? 10'(xmx) : 10'd0;
        e.ymin  = e.found ? 10'(ymn) : 10'd0;
        e.ymax  = e.found ? 10'(ymx) : 10'd0;
        e.cyc   = at_cyc;
        return e;
    endfunction

    task automatic clear_img();
        for (int l = 0; l < 8; l++)
            for (int p = 0; p < 12; p++) begin
                img_cur[l][p] = 8'd0;
                img_pre[l][p] = 8'd0;
            end
    endtask

    // Lines include unqualified cycles (clken=0, or clken=1 with href=0) carrying
    // a large luma difference that must not show up on the mask.
    task automatic drive_lines(input int nl, input int np);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < np; p++) begin
                href  = 1'b1;
                clken = 1'b1;
                y_cur = img_cur[l][p];
                y_pre = img_pre[l][p];
                mq.push_back(motion_of(y_cur, y_pre, thr));
                tick();
                if (p % 3 == 2) begin
                    clken = 1'b0;
                    y_cur = 8'hff;
                    y_pre = 8'h00;
                    tick();
                end
            end
            href  = 1'b0;
            clken = 1'b1;
            y_cur = 8'hff;
            y_pre = 8'h00;
            tick();
            clken = 1'b0;
            tick();
        end
    endtask

    task automatic run_frame(input int nl, input int np, input logic [7:0] t, input int vs_len);
        vs    = 1'b0;
        thr   = t;
        href  = 1'b0;
        clken = 1'b0;
        repeat (4) tick();
        drive_lines(nl, np);
        repeat (2) tick();
        // vsync is sampled at the next edge (cyc+1); box_valid is due two cycles later.
        bq.push_back(model_box(nl, np, t, 524287, cyc + 3));
        sq.push_back(model_box(nl, np, t, 7, cyc + 3));
        vs = 1'b1;
        repeat (vs_len) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_main"}, {22'd0, mclk, mbit, bval, bfound, gerr, bxmin, bxmax, bymin,
                                  bymax, bcount} == '0 ? 32'd0 : 32'd1, 32'd0);
        check_eq({tag, "_sat"}, {mclk_s, mbit_s, bval_s, bfound_s, gerr_s, bxmin_s, bxmax_s,
                                 bymin_s, bymax_s, bcount_s} == '0 ? 32'd0 : 32'd1, 32'd0);
    endtask

    // Monitor: mask latency/content and box publishes against the queues.
    initial begin
        logic     prev_q;
        logic     eb;
        box_exp_t e;
        prev_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_q = 1'b0;
                mq.delete();
            end else begin
                check_eq("mask_clken", 32'(mclk), 32'(prev_q));
                check_eq("mask_clken_sat", 32'(mclk_s), 32'(prev_q));
                if (prev_q) begin
                    if (mq.size() != 0) begin
                        eb = mq.pop_front();
                        check_eq("mask_bit", 32'(mbit), 32'(eb));
                        check_eq("mask_bit_sat", 32'(mbit_s), 32'(eb));
                    end else begin
                        check_eq("mask_underflow", 32'd1, 32'd0);
                    end
                end
                prev_q = href & clken;
                if (bval) begin
                    if (bq.size() == 0) begin
                        check_eq("box_valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = bq.pop_front();
                        check_eq("box_cycle", 32'(cyc), 32'(e.cyc));
                        check_eq("box_found", 32'(bfound), 32'(e.found));
                        check_eq("box_xmin", 32'(bxmin), 32'(e.xmin));
                        check_eq("box_xmax", 32'(bxmax), 32'(e.xmax));
                        check_eq("box_ymin", 32'(bymin), 32'(e.ymin));
                        check_eq("box_ymax", 32'(bymax), 32'(e.ymax));
                        check_eq("box_count", 32'(bcount), e.count);
                        check_eq("geom_err", 32'(gerr), 32'(e.err));
                    end
                end
                if (bval_s) begin
                    if (sq.size() == 0) begin
                        check_eq("box_valid_unexpected_sat", 32'd1, 32'd0);
                    end else begin
                        e = sq.pop_front();
                        check_eq("box_cycle_sat", 32'(cyc), 32'(e.cyc));
                        check_eq("box_found_sat", 32'(bfound_s), 32'(e.found));
                        check_eq("box_xmin_sat", 32'(bxmin_s), 32'(e.xmin));
                        check_eq("box_ymax_sat", 32'(bymax_s), 32'(e.ymax));
                        check_eq("box_count_sat", 32'(bcount_s), e.count);
                        check_eq("geom_err_sat", 32'(gerr_s), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        vs    = 1'b1;
        href  = 1'b0;
        clken = 1'b0;
        thr   = 8'd20;
        y_cur = 8'd0;
        y_pre = 8'd0;
        #1;
        check_all_zero("reset_outputs");
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Basic box
        clear_img();
        img_cur[1][2] = 8'd50;
        img_cur[3][5] = 8'd50;
        img_cur[4][3] = 8'd50;
        run_frame(6, 8, 8'd20, 6);

        // d == threshold everywhere: no motion
        clear_img();
        for (int l = 0; l < 6; l++)
            for (int p = 0; p < 8; p++) img_cur[l][p] = 8'd20;
        run_frame(6, 8, 8'd20, 6);

        // Negative difference is motion; small negative difference is not
        clear_img();
        img_cur[2][4] = 8'd10;
        img_pre[2][4] = 8'd200;
        img_cur[1][1] = 8'd5;
        img_pre[1][1] = 8'd15;
        run_frame(6, 8, 8'd20, 1);

        // Back-to-back: 10-pixel line, x=8,9 outside the window
        clear_img();
        img_cur[0][1] = 8'd60;
        img_cur[0][6] = 8'd60;
        img_cur[0][9] = 8'd60;
        run_frame(1, 10, 8'd20, 1);

        // Nine motion pixels: saturates the CW=3 counter at 7
        clear_img();
        for (int p = 0; p < 8; p++) img_cur[0][p] = 8'd90;
        img_cur[1][0] = 8'd90;
        run_frame(6, 8, 8'd20, 6);

        // Reset mid-frame: outputs clear at once, the interrupted frame is dropped
        clear_img();
        img_cur[0][3] = 8'd90;
        img_cur[1][6] = 8'd90;
        vs = 1'b0;
        repeat (4) tick();
        drive_lines(2, 8);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check_all_zero("midframe_reset");
        tick();
        rst = 1'b0;
        drive_lines(4, 8);
        vs = 1'b1;
        repeat (6) tick();

        // First full frame after reset; equality at threshold 100 is not motion
        clear_img();
        img_cur[0][0] = 8'd255;
        img_cur[5][7] = 8'd255;
        img_cur[2][4] = 8'd100;
        run_frame(6, 8, 8'd100, 6);

        vs = 1'b0;
        repeat (10) tick();
        check_eq("box_pending", 32'(bq.size()), 32'd0);
        check_eq("box_pending_sat", 32'(sq.size()), 32'd0);
        check_eq("mask_pending", 32'(mq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
